// File: rtl/accum_alu_if.sv
// accum_alu_if: command handshake and result/flag bundle for accum_alu_core.
interface accum_alu_if #(
    parameter int WIDTH = 8,
    parameter int REGS  = 4
);
    localparam int RA = $clog2(REGS);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [RA-1:0]    cmd_reg;
    logic [WIDTH-1:0] cmd_data;
    logic             res_valid;
    logic [WIDTH-1:0] res_data;
    logic [WIDTH-1:0] acc_out;
    logic             flag_c;
    logic             flag_z;
    logic             flag_n;
    logic             flag_v;
    modport master (
        output cmd_valid, cmd_op, cmd_reg, cmd_data,
        input  cmd_ready, res_valid, res_data, acc_out, flag_c, flag_z, flag_n, flag_v
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_reg, cmd_data,
        output cmd_ready, res_valid, res_data, acc_out, flag_c, flag_z, flag_n, flag_v
    );
endinterface

// File: rtl/accum_alu_core.sv
// accum_alu_core: WIDTH-bit accumulator with REGS-entry register file, 8-op ALU and C/Z/N/V flags,
// sequenced IDLE -> FETCH -> EXEC per accepted command.
module accum_alu_core #(
    parameter int WIDTH = 8,
    parameter int REGS  = 4
) (
    input logic        clk,
    input logic        rst_n,
    accum_alu_if.slave bus
);
    localparam int RA = $clog2(REGS);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [2:0] OP_LDI = 3'd0;
    localparam logic [2:0] OP_STR = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd4;
    localparam logic [2:0] OP_ADC = 3'd5;

    logic [1:0]       r_state;
    logic [2:0]       r_op;
    logic [RA-1:0]    r_idx;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_res_data;
    logic [WIDTH-1:0] r_regs [REGS];
    logic             r_res_valid;
    logic             r_c;
    logic             r_z;
    logic             r_n;
    logic             r_v;
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH-1:0] w_acc;
    logic [WIDTH:0]   w_sum;
    logic             w_cin;
    logic             w_arith;
    logic             w_logic;
    logic             w_c;
    logic             w_v;

    // SUB is folded into the adder as acc + ~B + 1, so one overflow rule covers ADD/SUB/ADC
    always_comb begin
        w_addend = (r_op == OP_SUB) ? ~r_b : r_b;
        w_cin    = (r_op == OP_SUB) || (r_op == OP_ADC && r_c);
        w_sum    = {1'b0, r_acc} + {1'b0, w_addend} + {{WIDTH{1'b0}}, w_cin};
        w_arith  = (r_op >= 3'd3) && (r_op <= 3'd5);
        w_logic  = &r_op[2:1];
        w_acc    = w_arith ? w_sum[WIDTH-1:0] :
                   w_logic ? (r_op[0] ? (r_acc ^ r_b) : (r_acc & r_b)) :
                   (r_op == OP_STR) ? r_acc : r_b;
        w_c      = w_arith ? w_sum[WIDTH] : w_logic ? 1'b0 : r_c;
        w_v      = w_arith ? (r_acc[WIDTH-1] == w_addend[WIDTH-1]) && (w_sum[WIDTH-1] != r_acc[WIDTH-1]) :
                   w_logic ? 1'b0 : r_v;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_idx       <= '0;
            r_data      <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_res_data  <= '0;
            r_res_valid <= 1'b0;
            r_c         <= 1'b0;
            r_z         <= 1'b1;
            r_n         <= 1'b0;
            r_v         <= 1'b0;
            for (int i = 0; i < REGS; i++) r_regs[i] <= '0;
        end else begin
            r_res_valid <= 1'b0;
            case (r_state)
                S_IDLE: if (bus.cmd_valid) begin
                    r_op    <= bus.cmd_op;
                    r_idx   <= bus.cmd_reg;
                    r_data  <= bus.cmd_data;
                    r_state <= S_FETCH;
                end
                S_FETCH: begin
                    r_b     <= (r_op == OP_LDI) ? r_data : r_regs[r_idx];
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (r_op == OP_STR) r_regs[r_idx] <= r_acc;
                    r_acc       <= w_acc;
                    r_c         <= w_c;
                    r_v         <= w_v;
                    r_z         <= (r_op == OP_STR) ? r_z : (w_acc == '0);
                    r_n         <= (r_op == OP_STR) ? r_n : w_acc[WIDTH-1];
                    r_res_data  <= w_acc;
                    r_res_valid <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = (r_state == S_IDLE);
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
    assign bus.acc_out   = r_acc;
    assign bus.flag_c    = r_c;
    assign bus.flag_z    = r_z;
    assign bus.flag_n    = r_n;
    assign bus.flag_v    = r_v;
endmodule
